// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port byte-enable memory among NREQ requesters, with burst lock.
// Grant is same-cycle combinational; read responses return WS cycles after grant, no backpressure on responses.
module mem_port_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 16,
    parameter int N       = 16,
    parameter int WS      = 2,
    parameter int MAXLOCK = 16
) (
    input  logic                        usr_clk,
    input  logic                        usr_reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0]             req_lock,
    input  logic [NREQ-1:0]             req_we,
    input  logic [NREQ*AW-1:0]          req_addr,
    input  logic [NREQ*8*N-1:0]         req_wdata,
    input  logic [NREQ*N-1:0]           req_wstrb,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [8*N-1:0]              rsp_rdata,
    output logic                        mem_we,
    output logic [AW-$clog2(N)-1:0]     mem_addr,
    output logic [N-1:0]                mem_be,
    output logic [8*N-1:0]              mem_wdata,
    input  logic [8*N-1:0]              mem_q
);
    localparam int DW      = 8 * N;
    localparam int MEM_LSB = $clog2(N);
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW      = $clog2(MAXLOCK + 1);

    logic [IDW-1:0]     r_ptr;
    logic               r_lock_vld;
    logic [IDW-1:0]     r_lock_own;
    logic [CW-1:0]      r_lock_cnt;
    logic [AW-MEM_LSB-1:0] r_addr_sh;
    logic [DW-1:0]      r_wdata_sh;

    logic               w_lock_hit;
    logic               w_found;
    logic               w_gnt;
    logic [IDW-1:0]     w_win;
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_idx;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_wdata;
    logic [N-1:0]       w_strb;
    logic               w_we;
    logic [CW-1:0]      w_cnt;
    logic               w_cont;
    logic [IDW-1:0]     w_ptr_nxt;
    logic               w_unused;

    // A live lock owner pre-empts the round-robin search entirely.
    always_comb begin
        w_lock_hit = r_lock_vld & req_valid[r_lock_own];
        w_found    = 1'b0;
        w_win      = r_lock_own;
        w_sum      = '0;
        w_idx      = '0;
        if (w_lock_hit) begin
            w_found = 1'b1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
                if (w_sum >= (IDW+1)'(NREQ)) begin
                    w_sum = w_sum - (IDW+1)'(NREQ);
                end
                w_idx = w_sum[IDW-1:0];
                if (!w_found && req_valid[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
            end
        end
    end

    assign w_gnt     = w_found & ~usr_reset;
    assign w_addr    = req_addr[int'(w_win)*AW +: AW];
    assign w_wdata   = req_wdata[int'(w_win)*DW +: DW];
    assign w_strb    = req_wstrb[int'(w_win)*N +: N];
    assign w_we      = req_we[w_win];
    assign w_cnt     = w_lock_hit ? r_lock_cnt : '0;
    assign w_cont    = req_lock[w_win] && (w_cnt < CW'(MAXLOCK - 1));
    assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_unused  = ^w_addr[MEM_LSB-1:0];

    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            r_ptr      <= '0;
            r_lock_vld <= 1'b0;
            r_lock_own <= '0;
            r_lock_cnt <= '0;
        end else if (w_gnt) begin
            if (w_cont) begin
                r_lock_vld <= 1'b1;
                r_lock_own <= w_win;
                r_lock_cnt <= w_cnt + 1'b1;
            end else begin
                r_lock_vld <= 1'b0;
                r_lock_cnt <= '0;
                r_ptr      <= w_ptr_nxt;
            end
        end else begin
            r_lock_vld <= 1'b0;
            r_lock_cnt <= '0;
        end
    end

    // Address/data shadow keeps the memory bus quiet while idle.
    always_ff @(posedge usr_clk) begin
        if (w_gnt) begin
            r_addr_sh  <= w_addr[AW-1:MEM_LSB];
            r_wdata_sh <= w_wdata;
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_gnt) begin
            req_ready[w_win] = 1'b1;
        end
        mem_we    = w_gnt & w_we;
        mem_be    = (w_gnt && w_we) ? w_strb : '0;
        mem_addr  = w_gnt ? w_addr[AW-1:MEM_LSB] : r_addr_sh;
        mem_wdata = w_gnt ? w_wdata : r_wdata_sh;
    end

    assign rsp_rdata = mem_q;

    generate
        if (WS == 0) begin : g_ws0
            always_comb begin
                rsp_valid = '0;
                if (w_gnt && !w_we) begin
                    rsp_valid[w_win] = 1'b1;
                end
            end
        end else begin : g_pipe
            logic [WS-1:0]  r_tag_vld;
            logic [IDW-1:0] r_tag_id [WS];

            always_ff @(posedge usr_clk) begin
                if (usr_reset) begin
                    r_tag_vld <= '0;
                end else begin
                    r_tag_vld[0] <= w_gnt & ~w_we;
                    for (int i = 1; i < WS; i++) begin
                        r_tag_vld[i] <= r_tag_vld[i-1];
                    end
                end
                r_tag_id[0] <= w_win;
                for (int i = 1; i < WS; i++) begin
                    r_tag_id[i] <= r_tag_id[i-1];
                end
            end

            // Gating on reset drops reads already in flight when reset arrives.
            always_comb begin
                rsp_valid = '0;
                if (r_tag_vld[WS-1] && !usr_reset) begin
                    rsp_valid[r_tag_id[WS-1]] = 1'b1;
                end
            end
        end
    endgenerate
endmodule
